// File: rtl/net1_scheduler.sv
// Two-requester round-robin scheduler: grants one request, evaluates a 4-bit operand
// for EVAL_CYCLES cycles, then holds the 3-bit result until the consumer acknowledges.
module net1_scheduler #(
    parameter int EVAL_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] din0,
    input  logic       req1,
    input  logic [3:0] din1,
    input  logic       ack,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       valid,
    output logic       id,
    output logic [2:0] dout,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES - 1);

    // Handshake: reqN is a level held until gntN pulses; valid holds id/dout
    // until ack is sampled high, and ack is ignored whenever valid is low.

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] opnd;
    logic [3:0] opnd_n;
    logic       prefer1;
    logic       prefer1_n;
    logic       gnt0_n;
    logic       gnt1_n;
    logic       valid_n;
    logic       id_n;
    logic [2:0] dout_n;
    logic       pick;

    // {a,b,c,d} -> {a^b, d, (c&d)|(~b&~d)}
    function automatic logic [2:0] eval_fn(input logic [3:0] op);
        logic x;
        logic y;
        logic z;
        x = op[3] ^ op[2];
        y = op[0];
        z = (op[1] & op[0]) | (~op[2] & ~op[0]);
        return {x, y, z};
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        opnd_n    = opnd;
        prefer1_n = prefer1;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        valid_n   = valid;
        id_n      = id;
        dout_n    = dout;
        // Tie goes to the requester that did not win last; otherwise the lone requester wins.
        pick      = (req0 && req1) ? prefer1 : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_n   = EVAL;
                    cnt_n     = EVAL_LOAD;
                    id_n      = pick;
                    opnd_n    = pick ? din1 : din0;
                    gnt0_n    = ~pick;
                    gnt1_n    = pick;
                    prefer1_n = ~pick;
                end
            end
            EVAL: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                    dout_n  = eval_fn(opnd);
                    valid_n = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (ack) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            opnd    <= 4'd0;
            prefer1 <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            id      <= 1'b0;
            dout    <= 3'b000;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            opnd    <= opnd_n;
            prefer1 <= prefer1_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            busy    <= (state_n != IDLE);
            valid   <= valid_n;
            id      <= id_n;
            dout    <= dout_n;
        end
    end

    assign state_dbg = state;

endmodule
